// File: rtl/multi_divisor_counter.sv
// Free-running modulo counter with NUM_DIV runtime-loadable divisibility channels.
// Latency: flags are combinational from registered state, zero cycles relative to count.
// Backpressure: none; en low freezes all state, cfg_load restarts the count.
module multi_divisor_counter #(
  parameter int unsigned                 WIDTH    = 8,
  parameter int unsigned                 NUM_DIV  = 2,
  parameter int unsigned                 DEF_LEN  = 100,
  parameter logic [NUM_DIV*WIDTH-1:0]    DEF_DIVS = {8'd5, 8'd3}
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       en,
  input  logic                       cfg_load,
  input  logic [WIDTH-1:0]           cfg_len,
  input  logic [NUM_DIV*WIDTH-1:0]   cfg_div,
  output logic [WIDTH-1:0]           count,
  output logic [NUM_DIV-1:0]         hit,
  output logic                       all_hit,
  output logic                       any_hit,
  output logic                       last
);

  localparam logic [WIDTH-1:0] DEF_LEN_W = WIDTH'(DEF_LEN);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] div_q [NUM_DIV];
  logic [WIDTH-1:0] res_q [NUM_DIV];
  logic [WIDTH-1:0] len_eff;
  logic             at_end;
  logic             active_any;
  logic             all_ok;

  // A period of 0 behaves like 1: the count is pinned at 0 and every cycle is the last.
  assign len_eff = (len_q == '0) ? ONE : len_q;
  assign at_end  = (count == len_eff - ONE);
  assign last    = at_end;

  // Counter, period, divisors and per-channel residues; load beats enable beats wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      len_q <= DEF_LEN_W;
      for (int i = 0; i < int'(NUM_DIV); i++) begin
        div_q[i] <= DEF_DIVS[i*WIDTH +: WIDTH];
        res_q[i] <= '0;
      end
    end else if (cfg_load) begin
      count <= '0;
      len_q <= cfg_len;
      for (int i = 0; i < int'(NUM_DIV); i++) begin
        div_q[i] <= cfg_div[i*WIDTH +: WIDTH];
        res_q[i] <= '0;
      end
    end else if (en) begin
      if (at_end) begin
        // Wrapping to 0 makes every residue 0, whatever the divisor.
        count <= '0;
        for (int i = 0; i < int'(NUM_DIV); i++) begin
          res_q[i] <= '0;
        end
      end else begin
        count <= count + ONE;
        // Inactive channels (divisor 0) free-run their residue; hit masks them out.
        for (int i = 0; i < int'(NUM_DIV); i++) begin
          res_q[i] <= (res_q[i] == div_q[i] - ONE) ? '0 : res_q[i] + ONE;
        end
      end
    end
  end

  // Per-channel hits and the reductions over channels whose divisor is nonzero.
  always_comb begin
    hit        = '0;
    active_any = 1'b0;
    all_ok     = 1'b1;
    for (int i = 0; i < int'(NUM_DIV); i++) begin
      hit[i] = (div_q[i] != '0) && (res_q[i] == '0);
      if (div_q[i] != '0) begin
        active_any = 1'b1;
        if (!hit[i]) begin
          all_ok = 1'b0;
        end
      end
    end
  end

  assign all_hit = active_any && all_ok;
  assign any_hit = |hit;

endmodule
